text_banner: RTL and testbench
==============================

TEXT_BANNER -- requirements
Module: text_banner

Interface
REQ-001 SHALL have parameter CHARS, default 8: number of glyph cells in the banner, legal range 1..16.
REQ-002 SHALL have parameter SCALE_LOG2, default 1: pixel magnification of 2^SCALE_LOG2, legal range 0..2.
REQ-003 SHALL have parameter X_POS, default 100: 12-bit left edge of the banner in screen pixels.
REQ-004 SHALL have parameter Y_POS, default 50: 12-bit top edge of the banner in screen pixels.
REQ-005 SHALL have parameter TYPE_FRAMES, default 4: frames per revealed character, 0..255; 0 means all characters are revealed at once.
REQ-006 SHALL have parameter BLINK_FRAMES, default 30: blink half-period in frames, 0..255; 0 means no blink.
REQ-007 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-008 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-009 SHALL have port x, input, 12 bits: current pixel column.
REQ-010 SHALL have port y, input, 12 bits: current pixel row.
REQ-011 SHALL have port frame_tick, input, 1 bit: one-cycle pulse, once per frame.
REQ-012 SHALL have port enable, input, 1 bit: display request, e.g. the winner flag.
REQ-013 SHALL have port restart, input, 1 bit: one-cycle pulse that restarts the reveal.
REQ-014 SHALL have port text, input, CHARS*4 bits: glyph codes; character i occupies bits [4i+3:4i], and character 0 is leftmost.
REQ-015 SHALL have port out, output, 1 bit: pixel-on.
REQ-016 SHALL have port done, output, 1 bit: high while all characters are revealed.

Function
REQ-017 Glyph cell SHALL be 6x8 base pixels: 5x7 glyph at columns 0-4 and rows 0-6; column 5 and row 7 are always off.
REQ-018 The banner box SHALL span x in [X_POS, X_POS + CHARS*6*2^SCALE_LOG2) and y in [Y_POS, Y_POS + 8*2^SCALE_LOG2); out SHALL be 0 outside the box.
REQ-019 Offsets (x-X_POS) and (y-Y_POS) SHALL be computed in 12 bits, with the box test done before any subtraction so wrap-around never yields a false hit.
REQ-020 Base column SHALL be offset >> SCALE_LOG2; char index = base column / 6; glyph column = base column mod 6; glyph row = row offset >> SCALE_LOG2.
REQ-021 Glyph code map SHALL be:
  - 0 = blank.
  - 1-13 = E, I, L, M, N, O, P, R, S, T, U, W, Y, using the team 5x7 font sheet.
  - 14 = '!'.
  - 15 = solid block, all 35 pixels on.
REQ-022 Font SHALL be a synchronous ROM indexed by {code, glyph row} that returns 5 bits, with bit 4 as the leftmost column.
REQ-023 Pipeline SHALL be 2 stages, so out reflects the x/y sampled 2 clk cycles earlier:
  - Stage 1 registers box hit, char index, glyph column and ROM address.
  - Stage 2 registers out.
REQ-024 FSM SHALL have states IDLE, TYPING and SHOW.
REQ-025 IDLE: out forced 0 at stage 2; reveal count = 0; on enable high go to TYPING, or to SHOW if TYPE_FRAMES = 0.
REQ-026 TYPING: the frame counter SHALL count frame_tick pulses; at TYPE_FRAMES ticks it clears and reveal increments; when reveal reaches CHARS, go to SHOW.
REQ-027 Character i SHALL be drawn only when i < reveal; in SHOW, reveal = CHARS.
REQ-028 SHOW: done = 1; when BLINK_FRAMES > 0, the visible flag toggles every BLINK_FRAMES ticks, starts visible, and out is 0 while not visible.
REQ-029 enable low in any state SHALL return the FSM to IDLE on the next edge, clearing the counters and the visible flag.
REQ-030 restart while enable is high SHALL clear reveal and the frame counter and enter TYPING, or SHOW if TYPE_FRAMES = 0; restart SHALL win over a simultaneous frame_tick.
REQ-031 Reveal and frame counters SHALL never exceed CHARS and 255 respectively, with no wrap-around.
REQ-032 text SHALL be sampled live at stage 1, so changing codes take effect 2 cycles later.

Reset
REQ-033 rst high SHALL immediately drive the following, independent of clk:
  - FSM to IDLE.
  - reveal, frame counter and pipeline registers to 0.
  - visible flag to 1.
  - out = 0 and done = 0.
REQ-034 After rst deasserts with enable already high, the FSM SHALL enter TYPING on the first clk edge.

Verification
Configuration for all scenarios: CHARS=4, SCALE_LOG2=1, X_POS=100, Y_POS=50, TYPE_FRAMES=2, BLINK_FRAMES=3, text=16'hF0F0 (chars 1 and 3 solid, chars 0 and 2 blank).
REQ-035 Geometry check:
  - Stimulus: fully revealed, x=112, y=50, then x=122, y=50, then x=112, y=66, then x=99, y=50.
  - Response: out = 1 exactly 2 cycles after (112,50); out = 0 for (122,50) (gap column), for (112,66) (outside box) and for (99,50).
REQ-036 Typewriter check:
  - Stimulus: enable rises, then frame ticks; x=112, y=50 (char 1) throughout.
  - Response: reveal = 1 after 2 ticks; char 1 is drawn only from tick 4; done = 1 after tick 8.
REQ-037 Blink check:
  - Stimulus: after done, 3 more frame ticks, then 3 more.
  - Response: out at (112,50) = 0 for the first 3 ticks, = 1 after the next 3.
REQ-038 Reset mid-typing:
  - Stimulus: rst pulse after tick 5.
  - Response: out = 0 and done = 0 immediately, without a clk edge; typing restarts from reveal = 0.
REQ-039 Restart and enable-drop check:
  - Stimulus: restart coincident with a frame_tick while in SHOW.
  - Response: reveal = 0, done = 0, state TYPING.
  - Stimulus: enable drop.
  - Response: IDLE on the next edge; out = 0 within 2 cycles.

Source files
------------

// File: rtl/text_banner.sv
// text_banner -- overlays a scaled 5x7-font text banner onto a raster scan,
// with a typewriter reveal (one more character every TYPE_FRAMES frames) and
// a blinking hold phase once every character is visible.
//
// Ports
//   clk, rst      : single clock; asynchronous active-high reset
//   x, y          : current pixel column / row (12 bits each)
//   frame_tick    : one-cycle pulse per frame, paces reveal and blink
//   enable        : display request; low parks the banner in IDLE
//   restart       : one-cycle pulse, restarts the reveal while enabled
//   text          : CHARS glyph codes, char i in bits [4i+3:4i], char 0 leftmost
//   out           : pixel-on, reflects the x/y/text sampled two cycles earlier
//   done          : high while every character is revealed (SHOW)
//   state_dbg     : FSM state, IDLE=0, TYPING=1, SHOW=2
//   reveal_dbg    : number of characters currently revealed
//
// Handshake: there is none; x/y/text are sampled every cycle and out is a
// fixed two-cycle-latency pipeline. frame_tick and restart are single-cycle
// strobes with priority enable-low > restart > frame_tick.
module text_banner #(
  parameter int CHARS        = 8,
  parameter int SCALE_LOG2   = 1,
  parameter int X_POS        = 100,
  parameter int Y_POS        = 50,
  parameter int TYPE_FRAMES  = 4,
  parameter int BLINK_FRAMES = 30
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [11:0]        x,
  input  logic [11:0]        y,
  input  logic               frame_tick,
  input  logic               enable,
  input  logic               restart,
  input  logic [CHARS*4-1:0] text,
  output logic               out,
  output logic               done,
  output logic [1:0]         state_dbg,
  output logic [4:0]         reveal_dbg
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TYPING = 2'd1,
    SHOW   = 2'd2
  } state_t;

  // Box limits are 13 bits wide so the right/bottom edge never wraps.
  localparam logic [12:0] X_LO     = 13'(X_POS);
  localparam logic [12:0] X_HI     = 13'(X_POS + CHARS * 6 * (2 ** SCALE_LOG2));
  localparam logic [12:0] Y_LO     = 13'(Y_POS);
  localparam logic [12:0] Y_HI     = 13'(Y_POS + 8 * (2 ** SCALE_LOG2));
  localparam logic [4:0]  REV_MAX  = 5'(CHARS);
  localparam logic [8:0]  TYPE_LIM = 9'(TYPE_FRAMES);
  localparam logic [8:0]  BLNK_LIM = 9'(BLINK_FRAMES);

  // 5x7 glyphs, row 0 first, bit 4 of each row is the leftmost column.
  localparam logic [34:0] G_E = {5'b11111, 5'b10000, 5'b10000, 5'b11110, 5'b10000, 5'b10000, 5'b11111};
  localparam logic [34:0] G_I = {5'b01110, 5'b00100, 5'b00100, 5'b00100, 5'b00100, 5'b00100, 5'b01110};
  localparam logic [34:0] G_L = {5'b10000, 5'b10000, 5'b10000, 5'b10000, 5'b10000, 5'b10000, 5'b11111};
  localparam logic [34:0] G_M = {5'b10001, 5'b11011, 5'b10101, 5'b10101, 5'b10001, 5'b10001, 5'b10001};
  localparam logic [34:0] G_N = {5'b10001, 5'b10001, 5'b11001, 5'b10101, 5'b10011, 5'b10001, 5'b10001};
  localparam logic [34:0] G_O = {5'b01110, 5'b10001, 5'b10001, 5'b10001, 5'b10001, 5'b10001, 5'b01110};
  localparam logic [34:0] G_P = {5'b11110, 5'b10001, 5'b10001, 5'b11110, 5'b10000, 5'b10000, 5'b10000};
  localparam logic [34:0] G_R = {5'b11110, 5'b10001, 5'b10001, 5'b11110, 5'b10100, 5'b10010, 5'b10001};
  localparam logic [34:0] G_S = {5'b01111, 5'b10000, 5'b10000, 5'b01110, 5'b00001, 5'b00001, 5'b11110};
  localparam logic [34:0] G_T = {5'b11111, 5'b00100, 5'b00100, 5'b00100, 5'b00100, 5'b00100, 5'b00100};
  localparam logic [34:0] G_U = {5'b10001, 5'b10001, 5'b10001, 5'b10001, 5'b10001, 5'b10001, 5'b01110};
  localparam logic [34:0] G_W = {5'b10001, 5'b10001, 5'b10001, 5'b10101, 5'b10101, 5'b10101, 5'b01010};
  localparam logic [34:0] G_Y = {5'b10001, 5'b10001, 5'b01010, 5'b00100, 5'b00100, 5'b00100, 5'b00100};
  localparam logic [34:0] G_X = {5'b00100, 5'b00100, 5'b00100, 5'b00100, 5'b00100, 5'b00000, 5'b00100};
  localparam logic [34:0] G_B = {35{1'b1}};

  // Font ROM contents indexed by {code, glyph row}; row 7 is the blank
  // spacer line under every glyph.
  function automatic logic [4:0] font_row(input logic [6:0] addr);
    logic [34:0] g;
    int          b;
    case (addr[6:3])
      4'd1:    g = G_E;
      4'd2:    g = G_I;
      4'd3:    g = G_L;
      4'd4:    g = G_M;
      4'd5:    g = G_N;
      4'd6:    g = G_O;
      4'd7:    g = G_P;
      4'd8:    g = G_R;
      4'd9:    g = G_S;
      4'd10:   g = G_T;
      4'd11:   g = G_U;
      4'd12:   g = G_W;
      4'd13:   g = G_Y;
      4'd14:   g = G_X;
      4'd15:   g = G_B;
      default: g = '0;
    endcase
    font_row = 5'd0;
    if (addr[2:0] != 3'd7) begin
      b = 34 - 5 * int'(addr[2:0]);
      font_row = g[b -: 5];
    end
  endfunction

  // ---------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------
  state_t     state_q, state_d;
  logic [4:0] reveal_q, reveal_d;
  logic [7:0] frame_q, frame_d;
  logic       visible_q, visible_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      reveal_q  <= 5'd0;
      frame_q   <= 8'd0;
      visible_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      reveal_q  <= reveal_d;
      frame_q   <= frame_d;
      visible_q <= visible_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    reveal_d  = reveal_q;
    frame_d   = frame_q;
    visible_d = visible_q;
    if (!enable) begin
      state_d   = IDLE;
      reveal_d  = 5'd0;
      frame_d   = 8'd0;
      visible_d = 1'b0;
    end else if (restart || state_q == IDLE) begin
      // Fresh start: restart beats any frame_tick in the same cycle.
      frame_d   = 8'd0;
      visible_d = 1'b1;
      if (TYPE_FRAMES == 0) begin
        state_d  = SHOW;
        reveal_d = REV_MAX;
      end else begin
        state_d  = TYPING;
        reveal_d = 5'd0;
      end
    end else if (frame_tick) begin
      case (state_q)
        TYPING: begin
          if ({1'b0, frame_q} + 9'd1 >= TYPE_LIM) begin
            frame_d = 8'd0;
            if (reveal_q + 5'd1 >= REV_MAX) begin
              reveal_d  = REV_MAX;
              state_d   = SHOW;
              visible_d = 1'b1;
            end else begin
              reveal_d = reveal_q + 5'd1;
            end
          end else if (frame_q != 8'hFF) begin
            frame_d = frame_q + 8'd1;
          end
        end
        SHOW: begin
          if (BLINK_FRAMES > 0) begin
            if ({1'b0, frame_q} + 9'd1 >= BLNK_LIM) begin
              frame_d   = 8'd0;
              visible_d = ~visible_q;
            end else if (frame_q != 8'hFF) begin
              frame_d = frame_q + 8'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Stage 1: box test, cell decode, font ROM read
  // ---------------------------------------------------------------------
  logic [11:0] x_off, y_off;
  logic [6:0]  col_base;
  logic        hit_d, hit_q;
  logic [3:0]  char_idx_d, char_idx_q;
  logic [2:0]  glyph_col_d, glyph_col_q;
  logic [2:0]  glyph_row_d;
  logic [3:0]  code_d;
  logic [6:0]  rom_addr_d;
  logic [4:0]  rom_row_d, rom_row_q;

  always_comb begin
    // The box test uses the raw coordinates, so the wrapped offsets below
    // only matter when hit_d is set.
    hit_d = ({1'b0, x} >= X_LO) && ({1'b0, x} < X_HI) &&
            ({1'b0, y} >= Y_LO) && ({1'b0, y} < Y_HI);
    x_off       = x - X_LO[11:0];
    y_off       = y - Y_LO[11:0];
    // Inside the box the base column is below 96, so 7 bits hold it.
    col_base    = 7'(x_off >> SCALE_LOG2);
    char_idx_d  = 4'(col_base / 7'd6);
    glyph_col_d = 3'(col_base % 7'd6);
    glyph_row_d = 3'(y_off >> SCALE_LOG2);
    code_d      = 4'd0;
    for (int i = 0; i < CHARS; i++) begin
      if (char_idx_d == 4'(i)) code_d = text[4*i +: 4];
    end
    rom_addr_d = {code_d, glyph_row_d};
    rom_row_d  = font_row(rom_addr_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_q       <= 1'b0;
      char_idx_q  <= 4'd0;
      glyph_col_q <= 3'd0;
      rom_row_q   <= 5'd0;
    end else begin
      hit_q       <= hit_d;
      char_idx_q  <= char_idx_d;
      glyph_col_q <= glyph_col_d;
      rom_row_q   <= rom_row_d;
    end
  end

  // ---------------------------------------------------------------------
  // Stage 2: column pick, reveal/blink gating
  // ---------------------------------------------------------------------
  logic out_d, out_q;
  logic pix;
  logic show_en;

  always_comb begin
    case (glyph_col_q)
      3'd0:    pix = rom_row_q[4];
      3'd1:    pix = rom_row_q[3];
      3'd2:    pix = rom_row_q[2];
      3'd3:    pix = rom_row_q[1];
      3'd4:    pix = rom_row_q[0];
      default: pix = 1'b0;  // column 5 is the inter-character gap
    endcase
    case (state_q)
      TYPING:  show_en = 1'b1;
      SHOW:    show_en = visible_q || (BLINK_FRAMES == 0);
      default: show_en = 1'b0;
    endcase
    out_d = hit_q && show_en && ({1'b0, char_idx_q} < reveal_q) && pix;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) out_q <= 1'b0;
    else     out_q <= out_d;
  end

  assign out        = out_q;
  assign done       = (state_q == SHOW);
  assign state_dbg  = state_q;
  assign reveal_dbg = reveal_q;

endmodule

// File: tb/tb_text_banner.sv
module tb_text_banner;

  localparam int CHARS = 4;
  localparam int SCALE_LOG2 = 1;
  localparam int X_POS = 100;
  localparam int Y_POS = 50;
  localparam int TF = 2;
  localparam int BF = 3;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_TYPING = 2'd1;
  localparam logic [1:0] ST_SHOW = 2'd2;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [11:0] x = 12'd0;
  logic [11:0] y = 12'd0;
  logic frame_tick = 1'b0;
  logic enable = 1'b0;
  logic restart = 1'b0;
  logic [15:0] text = 16'hF0F0;
  logic out, done;
  logic [1:0] state_dbg;
  logic [4:0] reveal_dbg;

  text_banner #(
    .CHARS(CHARS), .SCALE_LOG2(SCALE_LOG2), .X_POS(X_POS), .Y_POS(Y_POS),
    .TYPE_FRAMES(TF), .BLINK_FRAMES(BF)
  ) dut (
    .clk(clk), .rst(rst), .x(x), .y(y), .frame_tick(frame_tick),
    .enable(enable), .restart(restart), .text(text), .out(out), .done(done),
    .state_dbg(state_dbg), .reveal_dbg(reveal_dbg)
  );

  // scoreboard
  int n_checks = 0;
  int n_fail = 0;
  logic [0:0] exp_q[$];

  // reference model: enabled flag and frame ticks since the reveal started
  bit m_en = 1'b0;
  int m_ticks = 0;

  function automatic int model_reveal();
    int r;
    if (!m_en) return 0;
    r = m_ticks / TF;
    return (r > CHARS) ? CHARS : r;
  endfunction

  function automatic bit model_show();
    return m_en && (model_reveal() == CHARS);
  endfunction

  function automatic bit model_visible();
    if (!model_show()) return 1'b1;
    return (((m_ticks - CHARS * TF) / BF) % 2) == 0;
  endfunction

  function automatic logic exp_pixel(input int px, input int py, input logic [15:0] t);
    int scale, ox, oy, bc, ci, gc, gr;
    logic [3:0] code;
    scale = 1 << SCALE_LOG2;
    if (!m_en) return 1'b0;
    if (px < X_POS || px >= X_POS + CHARS * 6 * scale) return 1'b0;
    if (py < Y_POS || py >= Y_POS + 8 * scale) return 1'b0;
    ox = px - X_POS;
    oy = py - Y_POS;
    bc = ox / scale;
    ci = bc / 6;
    gc = bc % 6;
    gr = oy / scale;
    if (ci >= model_reveal()) return 1'b0;
    if (!model_visible()) return 1'b0;
    code = t[4*ci +: 4];
    if (code == 4'hF) return (gc < 5) && (gr < 7);
    return 1'b0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic do_tick();
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    m_ticks++;
  endtask

  // Tick once with (112,50) held, check counters, then the settled pixel.
  task automatic tick_and_check(input string tag);
    do_tick();
    check({tag, "_reveal"}, 32'(reveal_dbg), 32'(model_reveal()));
    check({tag, "_done"}, 32'(done), 32'(model_show()));
    repeat (2) @(negedge clk);
    check({tag, "_out"}, 32'(out), 32'(exp_pixel(112, 50, 16'hF0F0)));
  endtask

  task automatic check_point(input string tag, input int px, input int py, input logic e);
    @(negedge clk);
    x = 12'(px);
    y = 12'(py);
    repeat (2) @(negedge clk);
    check(tag, 32'(out), 32'(e));
  endtask

  // One pixel per cycle, compared two cycles later against the queue.
  task automatic drive_pixel(input int px, input int py, input logic [15:0] t);
    @(negedge clk);
    if (exp_q.size() == 2) check("sweep", 32'(out), 32'(exp_q.pop_front()));
    x = 12'(px);
    y = 12'(py);
    text = t;
    exp_q.push_back(exp_pixel(px, py, t));
  endtask

  task automatic flush_pixels();
    while (exp_q.size() > 0) begin
      @(negedge clk);
      check("sweep", 32'(out), 32'(exp_q.pop_front()));
    end
  endtask

  task automatic random_sweep(input int n);
    logic [15:0] t;
    for (int k = 0; k < n; k++) begin
      for (int i = 0; i < CHARS; i++) t[4*i +: 4] = ($urandom_range(0, 1) == 1) ? 4'hF : 4'h0;
      drive_pixel($urandom_range(90, 155), $urandom_range(44, 72), t);
    end
    flush_pixels();
  endtask

  task automatic hold_banner_pixel();
    @(negedge clk);
    x = 12'd112;
    y = 12'd50;
    text = 16'hF0F0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // reset state
    x = 12'd112;
    y = 12'd50;
    repeat (2) @(negedge clk);
    check("rst_out", 32'(out), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_state", 32'(state_dbg), 32'(ST_IDLE));
    check("rst_reveal", 32'(reveal_dbg), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_state", 32'(state_dbg), 32'(ST_IDLE));

    // typewriter
    enable = 1'b1;
    m_en = 1'b1;
    m_ticks = 0;
    @(negedge clk);
    check("en_state", 32'(state_dbg), 32'(ST_TYPING));
    check("en_reveal", 32'(reveal_dbg), 32'd0);
    repeat (2) @(negedge clk);
    check("en_out", 32'(out), 32'd0);
    for (int i = 1; i <= 4; i++) tick_and_check($sformatf("type_t%0d", i));
    random_sweep(30);
    hold_banner_pixel();
    for (int i = 5; i <= 8; i++) tick_and_check($sformatf("type_t%0d", i));
    check("show_state", 32'(state_dbg), 32'(ST_SHOW));
    check("show_done", 32'(done), 32'd1);

    // geometry
    check_point("geo_112_50", 112, 50, 1'b1);
    check_point("geo_122_50", 122, 50, 1'b0);
    check_point("geo_112_66", 112, 66, 1'b0);
    check_point("geo_99_50", 99, 50, 1'b0);
    random_sweep(40);
    hold_banner_pixel();

    // blink
    for (int i = 9; i <= 11; i++) tick_and_check($sformatf("blink_t%0d", i));
    check("blink_off", 32'(out), 32'd0);
    random_sweep(20);
    hold_banner_pixel();
    for (int i = 12; i <= 14; i++) tick_and_check($sformatf("blink_t%0d", i));
    check("blink_on", 32'(out), 32'd1);

    // restart coincident with frame_tick in SHOW
    @(negedge clk);
    restart = 1'b1;
    frame_tick = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    frame_tick = 1'b0;
    m_ticks = 0;
    check("restart_state", 32'(state_dbg), 32'(ST_TYPING));
    check("restart_reveal", 32'(reveal_dbg), 32'd0);
    check("restart_done", 32'(done), 32'd0);

    // reset mid-typing
    for (int i = 1; i <= 5; i++) tick_and_check($sformatf("retype_t%0d", i));
    check("pre_rst_out", 32'(out), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_out", 32'(out), 32'd0);
    check("async_rst_done", 32'(done), 32'd0);
    check("async_rst_state", 32'(state_dbg), 32'(ST_IDLE));
    check("async_rst_reveal", 32'(reveal_dbg), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    m_ticks = 0;
    @(negedge clk);
    check("post_rst_state", 32'(state_dbg), 32'(ST_TYPING));
    check("post_rst_reveal", 32'(reveal_dbg), 32'd0);
    for (int i = 1; i <= 8; i++) tick_and_check($sformatf("post_rst_t%0d", i));
    check("post_rst_show", 32'(state_dbg), 32'(ST_SHOW));

    // enable drop
    @(negedge clk);
    enable = 1'b0;
    m_en = 1'b0;
    @(negedge clk);
    check("drop_state", 32'(state_dbg), 32'(ST_IDLE));
    check("drop_done", 32'(done), 32'd0);
    check("drop_reveal", 32'(reveal_dbg), 32'd0);
    @(negedge clk);
    check("drop_out", 32'(out), 32'd0);
    do_tick();
    check("idle_tick_reveal", 32'(reveal_dbg), 32'd0);
    random_sweep(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
